// File: rtl/write_back_buffer_pkg.sv
// Shared types and field widths for the write-back buffer
// and the cache controller that feeds it.
package write_back_buffer_pkg;

  localparam int WBB_ADDR_W = 16;
  localparam int WBB_DATA_W = 32;
  localparam int WBB_DEPTH  = 4;
  localparam int WBB_PTR_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } wbb_state_e;

endpackage

// File: rtl/write_back_buffer_match.sv
// Per-entry address compare with youngest-match select,
// shared by the coalescing and lookup paths.
module wbb_match #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [DEPTH-1:0]                 valid_i,
  input  logic [DEPTH-1:0]                 excl_i,
  input  logic [PTR_W-1:0]                 rd_ptr_i,
  input  logic [ADDR_WIDTH-1:0]            key_i,
  output logic                             hit_o,
  output logic [PTR_W-1:0]                 sel_o
);

  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] idx;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_i[i] && !excl_i[i]
                 && (addr_i[i] == key_i);
    end
  end

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_i + PTR_W'(k);
      if (match[idx]) begin
        hit_o = 1'b1;
        sel_o = idx;
      end
    end
  end

endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer: coalescing FIFO of dirty victims
// drained to RAM whenever the RAM port is granted.
module write_back_buffer
  import write_back_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = WBB_ADDR_W,
  parameter int DATA_WIDTH = WBB_DATA_W,
  parameter int DEPTH      = WBB_DEPTH,
  parameter int PTR_W      = WBB_PTR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data,
  input  logic                  ram_grant,
  output logic                  ram_writeEnable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_writeData,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count
);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  wbb_state_e       state_q, state_d;

  logic             drain, push_fire, alloc;
  logic             coal_hit, lk_hit;
  logic [PTR_W-1:0] coal_sel, lk_sel;
  logic [DEPTH-1:0] excl, no_excl;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign count = count_q;

  assign drain           = !empty && ram_grant;
  assign ram_writeEnable = drain;
  assign ram_addr      = empty ? '0 : addr_q[rd_ptr_q];
  assign ram_writeData = empty ? '0 : data_q[rd_ptr_q];

  // The head leaving this cycle must not absorb a push.
  always_comb begin
    excl = '0;
    if (drain) excl[rd_ptr_q] = 1'b1;
  end

  assign no_excl = '0;

  wbb_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_push_match (
    .addr_i   (addr_q),
    .valid_i  (valid_q),
    .excl_i   (excl),
    .rd_ptr_i (rd_ptr_q),
    .key_i    (push_addr),
    .hit_o    (coal_hit),
    .sel_o    (coal_sel)
  );

  wbb_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_lookup_match (
    .addr_i   (addr_q),
    .valid_i  (valid_q),
    .excl_i   (no_excl),
    .rd_ptr_i (rd_ptr_q),
    .key_i    (lookup_addr),
    .hit_o    (lk_hit),
    .sel_o    (lk_sel)
  );

  assign push_ready = (state_q != FLUSH)
                      && (!full || coal_hit);
  assign push_fire  = push_valid && push_ready;
  assign alloc      = push_fire && !coal_hit;

  assign lookup_hit  = lk_hit;
  assign lookup_data = lk_hit ? data_q[lk_sel] : '0;
  assign flush_done  = (state_q == FLUSH) && empty;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (drain) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (alloc) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + (PTR_W+1)'(alloc)
                      - (PTR_W+1)'(drain);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req)   state_d = FLUSH;
        else if (!empty) state_d = DRAIN;
      end
      DRAIN: begin
        if (flush_req)  state_d = FLUSH;
        else if (empty) state_d = IDLE;
      end
      FLUSH: begin
        if (empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Payload needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end else if (push_fire) begin
      data_q[coal_sel] <= push_data;
    end
  end

endmodule

// File: tb/tb_write_back_buffer.sv
// Bench for write_back_buffer: directed scenarios then
// random traffic against a queue-based reference model.
module tb_write_back_buffer;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [AW-1:0] push_addr = '0;
  logic [DW-1:0] push_data = '0;
  logic [AW-1:0] lookup_addr = '0;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic          ram_grant = 1'b0;
  logic          ram_writeEnable;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_writeData;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          empty;
  logic          full;
  logic [PW:0]   count;

  write_back_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .PTR_W      (PW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .push_addr       (push_addr),
    .push_data       (push_data),
    .lookup_addr     (lookup_addr),
    .lookup_hit      (lookup_hit),
    .lookup_data     (lookup_data),
    .ram_grant       (ram_grant),
    .ram_writeEnable (ram_writeEnable),
    .ram_addr        (ram_addr),
    .ram_writeData   (ram_writeData),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .empty           (empty),
    .full            (full),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   flushing = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    flushing = 1'b0;
  endtask

  // One clock: drive, compare against the model, advance it.
  task automatic step(input bit pv,
                      input logic [AW-1:0] pa,
                      input logic [DW-1:0] pd,
                      input bit g,
                      input bit fr,
                      input logic [AW-1:0] la);
    int ci, li, n;
    bit e, dr, rdy;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, ld;
    @(negedge clk);
    push_valid  = pv;
    push_addr   = pa;
    push_data   = pd;
    ram_grant   = g;
    flush_req   = fr;
    lookup_addr = la;
    #1;
    n  = q.size();
    e  = (n == 0);
    dr = !e && g;
    ea = '0;
    ed = '0;
    if (!e) begin
      ea = q[0].a;
      ed = q[0].d;
    end
    ci = -1;
    li = -1;
    for (int j = 0; j < n; j++) begin
      if (!(dr && j == 0) && q[j].a == pa) ci = j;
      if (q[j].a == la) li = j;
    end
    ld = '0;
    if (li >= 0) ld = q[li].d;
    rdy = !flushing && (n < DEPTH || ci >= 0);
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(e));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("push_ready", 64'(push_ready), 64'(rdy));
    chk("ram_we", 64'(ram_writeEnable), 64'(dr));
    chk("ram_addr", 64'(ram_addr), 64'(ea));
    chk("ram_data", 64'(ram_writeData), 64'(ed));
    chk("lookup_hit", 64'(lookup_hit), 64'(li >= 0));
    chk("lookup_data", 64'(lookup_data), 64'(ld));
    chk("flush_done", 64'(flush_done),
        64'(flushing && e));
    if (pv && rdy && ci >= 0) q[ci].d = pd;
    if (dr) void'(q.pop_front());
    if (pv && rdy && ci < 0) q.push_back('{pa, pd});
    flushing = flushing ? !e : fr;
  endtask

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_we", 64'(ram_writeEnable), 64'd0);
    chk("rst_done", 64'(flush_done), 64'd0);
    chk("rst_hit", 64'(lookup_hit), 64'd0);
    chk("rst_ready", 64'(push_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // single push, lookup, drain
    step(1, 16'h0010, 32'hAAAA0001, 0, 0, 16'h0010);
    step(0, 16'h0000, 32'h0, 0, 0, 16'h0010);
    chk("r24_count", 64'(count), 64'd1);
    chk("r24_hit", 64'(lookup_hit), 64'd1);
    chk("r24_data", 64'(lookup_data), 64'hAAAA0001);
    step(0, 16'h0000, 32'h0, 1, 0, 16'h0010);
    chk("r24_we", 64'(ram_writeEnable), 64'd1);
    chk("r24_addr", 64'(ram_addr), 64'h0010);
    step(0, 16'h0000, 32'h0, 0, 0, 16'h0010);
    chk("r24_empty", 64'(empty), 64'd1);

    // fill, then coalesce into a full buffer
    for (int i = 1; i <= 4; i++)
      step(1, 16'(i * 16), 32'(i), 0, 0, 16'h0);
    step(1, 16'h0050, 32'h5, 0, 0, 16'h0020);
    chk("r25_full", 64'(full), 64'd1);
    chk("r25_rdy_new", 64'(push_ready), 64'd0);
    step(1, 16'h0020, 32'hBEEF, 0, 0, 16'h0020);
    chk("r25_rdy_old", 64'(push_ready), 64'd1);
    step(0, 16'h0000, 32'h0, 0, 0, 16'h0020);
    chk("r25_count", 64'(count), 64'd4);
    chk("r25_data", 64'(lookup_data), 64'hBEEF);

    // push matching the head while it drains
    step(0, 16'h0000, 32'h0, 1, 0, 16'h0);
    step(0, 16'h0000, 32'h0, 1, 0, 16'h0);
    step(1, 16'h0030, 32'h1234, 1, 0, 16'h0030);
    chk("r26_head", 64'(ram_addr), 64'h0030);
    chk("r26_rdy", 64'(push_ready), 64'd1);
    step(0, 16'h0000, 32'h0, 1, 0, 16'h0);
    step(0, 16'h0000, 32'h0, 1, 0, 16'h0);
    chk("r26_addr", 64'(ram_addr), 64'h0030);
    chk("r26_data", 64'(ram_writeData), 64'h1234);

    // flush of three entries
    for (int i = 1; i <= 3; i++)
      step(1, 16'(i * 256), 32'(i + 100), 0, 0, 16'h0);
    step(0, 16'h0000, 32'h0, 0, 1, 16'h0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 16'h0400, 32'h9, 1, 0, 16'h0);
      chk("r27_rdy", 64'(push_ready), 64'd0);
      chk("r27_addr", 64'(ram_addr), 64'(i * 256));
      chk("r27_done_lo", 64'(flush_done), 64'd0);
    end
    step(0, 16'h0000, 32'h0, 1, 0, 16'h0);
    chk("r27_done", 64'(flush_done), 64'd1);
    chk("r27_empty", 64'(empty), 64'd1);
    step(0, 16'h0000, 32'h0, 1, 0, 16'h0);
    chk("r27_done_end", 64'(flush_done), 64'd0);

    // flush while already empty
    step(0, 16'h0000, 32'h0, 0, 1, 16'h0);
    step(0, 16'h0000, 32'h0, 0, 0, 16'h0);
    chk("r17_done", 64'(flush_done), 64'd1);

    // reset in the middle of a drain
    step(1, 16'h0500, 32'h55, 0, 0, 16'h0);
    step(1, 16'h0600, 32'h66, 0, 0, 16'h0);
    @(negedge clk);
    push_valid  = 1'b0;
    ram_grant   = 1'b1;
    lookup_addr = 16'h0500;
    #1;
    chk("r28_we_pre", 64'(ram_writeEnable), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r28_we", 64'(ram_writeEnable), 64'd0);
    chk("r28_count", 64'(count), 64'd0);
    chk("r28_hit", 64'(lookup_hit), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ram_grant = 1'b0;
    step(1, 16'h0700, 32'h77, 0, 0, 16'h0700);
    step(0, 16'h0000, 32'h0, 0, 0, 16'h0700);
    chk("r28_after", 64'(count), 64'd1);
    step(0, 16'h0000, 32'h0, 1, 0, 16'h0);

    // pointer wrap with push/drain pairs
    for (int i = 0; i < 10; i++) begin
      step(1, 16'(16'h0800 + i), 32'(i), 0, 0, 16'h0);
      step(0, 16'h0000, 32'h0, 1, 0, 16'h0);
      chk("r29_addr", 64'(ram_addr), 64'(16'h0800 + i));
    end

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 3) != 0),
           16'(16 * $urandom_range(1, 6)),
           $urandom(),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 39) == 0),
           16'(16 * $urandom_range(1, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/write_back_buffer.md
WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 16, word address width; DATA_WIDTH, default 32, data width; DEPTH, default 4, number of entries (power of 2, >=2); PTR_W, default 2, log2(DEPTH).
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset).
REQ-003 SHALL have upstream eviction ports: push_valid (in, 1, cache controller offers dirty victim); push_ready (out, 1, buffer accepts); push_addr (in, ADDR_WIDTH, victim word address); push_data (in, DATA_WIDTH, victim data).
REQ-004 SHALL have lookup ports: lookup_addr (in, ADDR_WIDTH, miss address); lookup_hit (out, 1, address is pending in buffer); lookup_data (out, DATA_WIDTH, pending data).
REQ-005 SHALL have RAM-side ports: ram_grant (in, 1, RAM port free this cycle); ram_writeEnable (out, 1); ram_addr (out, ADDR_WIDTH); ram_writeData (out, DATA_WIDTH).
REQ-006 SHALL have control/status ports: flush_req (in, 1, drain all); flush_done (out, 1, one-cycle pulse); empty (out, 1); full (out, 1); count (out, PTR_W+1, occupied entries).

Function
REQ-007 SHALL store entries as a circular FIFO (wr_ptr, rd_ptr, count); pointers wrap from DEPTH-1 to 0.
REQ-008 SHALL accept a push on a rising edge when push_valid && push_ready.
REQ-009 SHALL coalesce: a push whose address matches a valid entry not being drained that cycle overwrites that entry's data; count unchanged.
REQ-010 SHALL allocate a new entry at wr_ptr when a push does not coalesce; if the only match is the entry draining that same cycle, a new entry is allocated.
REQ-011 SHALL drive push_ready = !full && state != FLUSH; a coalescing push is also accepted when full (push_ready=1 if lookup of push_addr hits a non-draining entry).
REQ-012 SHALL compute lookup_hit/lookup_data combinationally from all valid entries; on multiple matches (only possible per REQ-010) the youngest wins; same-cycle push not forwarded.
REQ-013 SHALL drain: when !empty and ram_grant=1, combinationally assert ram_writeEnable with the head entry's addr/data; head retires on that edge; max one retire per cycle.
REQ-014 SHALL keep ram_writeEnable=0 whenever empty or ram_grant=0; ram_addr/ram_writeData hold the head entry (zero when empty).
REQ-015 SHALL handle push and retire in the same cycle: count unchanged for allocating push, count-1 for coalescing push.
REQ-016 SHALL use FSM states IDLE, DRAIN, FLUSH: IDLE->DRAIN when !empty; DRAIN->IDLE when empty; any->FLUSH on flush_req; FLUSH->IDLE when empty, asserting flush_done for exactly that one cycle.
REQ-017 SHALL assert flush_done one cycle after flush_req when flush_req arrives while already empty.
REQ-018 SHALL drive full = (count==DEPTH), empty = (count==0).

Reset
REQ-019 SHALL, on rst_n low (asynchronous), clear all valid bits, pointers and count, enter IDLE, force push_ready=1-capable state, and drive ram_writeEnable=0, flush_done=0, lookup_hit=0, empty=1, full=0, count=0.
REQ-020 SHALL discard all pending entries on reset mid-drain; no partial RAM write occurs after rst_n falls.
REQ-021 SHALL not require entry data storage to be reset.

Structure
REQ-022 SHALL place FSM state encoding (IDLE=0, DRAIN=1, FLUSH=2) and the entry-field width constants in a shared package used by cache_controller.
REQ-023 SHALL contain one natural sub-module, wbb_match, computing per-entry address match vector and youngest-match select for REQ-009 and REQ-012.

Verification
REQ-024 SHALL cover: push (0x0010,0xAAAA0001) with ram_grant=0 -> count=1, lookup_addr=0x0010 gives hit, data 0xAAAA0001; ram_grant=1 next cycle -> ram_writeEnable=1, ram_addr=0x0010, then empty=1.
REQ-025 SHALL cover: ram_grant=0, push 4 distinct addrs -> full=1, push_ready=0 for new addr 0x0050, push_ready=1 for existing 0x0020 with data 0xBEEF overwriting that entry, count stays 4.
REQ-026 SHALL cover: head 0x0030 draining with ram_grant=1 while pushing 0x0030/0x1234 -> new entry allocated, next drain writes 0x1234 to 0x0030.
REQ-027 SHALL cover: 3 entries, flush_req pulse, ram_grant=1 -> push_ready=0 during FLUSH, 3 consecutive RAM writes in FIFO order, flush_done single pulse same cycle empty=1.
REQ-028 SHALL cover: rst_n low mid-drain with count=2 -> immediately ram_writeEnable=0, count=0, lookup_hit=0; after release, push accepted normally.
REQ-029 SHALL cover: pointer wrap: 10 push/drain pairs with DEPTH=4 -> RAM writes in push order, no lost or duplicated address.
